// File: rtl/lfsr_stream_gen.sv
// Fibonacci LFSR generator with a valid/ready output stream, run-time seed load, zero-state recovery and wrap pulse.
// Optional step counter output enabled by defining LFSR_STEP_COUNT_EN.
module lfsr_stream_gen #(
    parameter int              WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS = 16'b0000000000101101,
    parameter logic [WIDTH-1:0] SEED = 16'b1010110011100001
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             q_ready,
    output logic             q_valid,
    output logic [WIDTH-1:0] q,
    output logic             bit_out,
    output logic             wrap,
    output logic             lockup
`ifdef LFSR_STEP_COUNT_EN
    ,
    output logic [WIDTH-1:0] step_count
`endif
);

    if (SEED == '0) begin : g_bad_seed
        $error("lfsr_stream_gen: SEED must be non-zero");
    end
    if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
        $error("lfsr_stream_gen: WIDTH must be within 3..32");
    end

    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] shift_nxt;
    logic             valid_q, valid_d;
    logic             wrap_q, wrap_d;
    logic             lock_q, lock_d;
    logic             step;
    logic             fb;

    always_comb begin
        step      = valid_q & q_ready;
        fb        = ^(state_q & TAPS);
        shift_nxt = {fb, state_q[WIDTH-1:1]};
        state_d   = state_q;
        valid_d   = 1'b1;
        wrap_d    = 1'b0;
        lock_d    = 1'b0;
        // A load swallows a coincident step: the beat is consumed without advancing.
        if (load) begin
            if (load_value == '0) begin
                state_d = SEED;
                lock_d  = 1'b1;
            end else begin
                state_d = load_value;
            end
        end else if (step) begin
            if (shift_nxt == '0) begin
                state_d = SEED;
                lock_d  = 1'b1;
            end else begin
                state_d = shift_nxt;
                wrap_d  = (shift_nxt == SEED);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SEED;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
            lock_q  <= lock_d;
        end
    end

    assign q       = state_q;
    assign q_valid = valid_q;
    assign bit_out = state_q[0];
    assign wrap    = wrap_q;
    assign lockup  = lock_q;

`ifdef LFSR_STEP_COUNT_EN
    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load || lock_d || wrap_d) begin
            cnt_d = '0;
        end else if (step) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign step_count = cnt_q;
`endif

endmodule

// File: tb/tb_lfsr_stream_gen.sv
// Bench for lfsr_stream_gen: directed scenarios plus random traffic against a sequence-index reference model.
module tb_lfsr_stream_gen;

    localparam int         W    = 4;
    localparam logic [3:0] TAPS = 4'b0011;
    localparam logic [3:0] SEED = 4'b0001;
    localparam int         PERIOD = 15;

    logic       clk = 1'b0;
    logic       reset, load, q_ready;
    logic [3:0] load_value;
    logic       q_valid, bit_out, wrap, lockup;
    logic [3:0] q;
`ifdef LFSR_STEP_COUNT_EN
    logic [3:0] step_count;
`endif

    always #5 clk = ~clk;

    lfsr_stream_gen #(.WIDTH(W), .TAPS(TAPS), .SEED(SEED)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_value (load_value),
        .q_ready    (q_ready),
        .q_valid    (q_valid),
        .q          (q),
        .bit_out    (bit_out),
        .wrap       (wrap),
        .lockup     (lockup)
`ifdef LFSR_STEP_COUNT_EN
        ,
        .step_count (step_count)
`endif
    );

    // Reference model: the maximal sequence as a table, state tracked as a position in it.
    logic [3:0] seq [PERIOD];
    int  m_idx;
    bit  m_valid, m_wrap, m_lock;
    int  m_cnt;
    int  errors = 0;
    int  checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int index_of(input logic [3:0] v);
        for (int i = 0; i < PERIOD; i++)
            if (seq[i] == v) return i;
        return 0;
    endfunction

    task automatic cyc(input bit r, input bit ld, input logic [3:0] lv, input bit rdy);
        reset = r; load = ld; load_value = lv; q_ready = rdy;
        if (r) begin
            m_idx = 0; m_valid = 0; m_wrap = 0; m_lock = 0; m_cnt = 0;
        end else begin
            m_wrap = 0; m_lock = 0;
            if (ld) begin
                if (lv == 4'd0) begin
                    m_idx = 0; m_lock = 1;
                end else begin
                    m_idx = index_of(lv);
                end
                m_cnt = 0;
            end else if (m_valid && rdy) begin
                m_idx = (m_idx + 1) % PERIOD;
                if (m_idx == 0) begin
                    m_wrap = 1; m_cnt = 0;
                end else begin
                    m_cnt = (m_cnt + 1) % 16;
                end
            end
            m_valid = 1;
        end
        @(posedge clk);
        #1;
        chk("q", q, seq[m_idx]);
        chk("q_valid", q_valid, m_valid);
        chk("bit_out", bit_out, seq[m_idx][0]);
        chk("wrap", wrap, m_wrap);
        chk("lockup", lockup, m_lock);
`ifdef LFSR_STEP_COUNT_EN
        chk("step_count", step_count, m_cnt);
`endif
    endtask

    initial begin
        logic [3:0] exp1 [6];
        exp1[0] = 4'b0001; exp1[1] = 4'b1000; exp1[2] = 4'b0100;
        exp1[3] = 4'b0010; exp1[4] = 4'b1001; exp1[5] = 4'b1100;

        seq[0] = SEED;
        for (int k = 0; k < PERIOD - 1; k++)
            seq[k+1] = (seq[k] >> 1) | 4'(($countones(seq[k] & TAPS) % 2) << 3);

        // Scenario 1: reset then the first six states.
        cyc(1, 0, 4'd0, 1);
        cyc(1, 0, 4'd0, 1);
        chk("s1_reset_q", q, 4'b0001);
        chk("s1_reset_valid", q_valid, 1'b0);
        for (int k = 0; k < 6; k++) begin
            cyc(0, 0, 4'd0, 1);
            chk("s1_seq", q, exp1[k]);
        end

        // Scenario 2: fifteen steps return to SEED with a single wrap pulse.
        cyc(1, 0, 4'd0, 1);
        cyc(0, 0, 4'd0, 1);
        for (int i = 1; i <= PERIOD; i++) begin
            cyc(0, 0, 4'd0, 1);
            if (i == PERIOD) begin
                chk("s2_wrap", wrap, 1'b1);
                chk("s2_q", q, 4'b0001);
            end
        end
        cyc(0, 0, 4'd0, 0);
        chk("s2_wrap_clear", wrap, 1'b0);

        // Scenario 3: back-pressure holds the current sample.
        cyc(1, 0, 4'd0, 1);
        cyc(0, 0, 4'd0, 1);
        cyc(0, 0, 4'd0, 1);
        cyc(0, 0, 4'd0, 1);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 4'd0, 0);
            chk("s3_hold", q, 4'b0100);
        end
        cyc(0, 0, 4'd0, 1);
        chk("s3_resume", q, 4'b0010);

        // Scenario 4: load wins over a coincident step.
        cyc(0, 1, 4'b1011, 1);
        chk("s4_load", q, 4'b1011);
        cyc(0, 0, 4'd0, 1);
        chk("s4_step", q, 4'b0101);

        // Scenario 5: zero load is replaced by SEED with a lockup pulse.
        cyc(0, 1, 4'b0000, 1);
        chk("s5_q", q, 4'b0001);
        chk("s5_lockup", lockup, 1'b1);
        chk("s5_wrap", wrap, 1'b0);
        cyc(0, 0, 4'd0, 0);
        chk("s5_lockup_clear", lockup, 1'b0);

        // Scenario 6: reset mid-stream restarts the sequence.
        cyc(0, 1, 4'b1101, 0);
        cyc(1, 0, 4'd0, 1);
        chk("s6_reset_q", q, 4'b0001);
        chk("s6_reset_valid", q_valid, 1'b0);
        for (int k = 0; k < 6; k++) begin
            cyc(0, 0, 4'd0, 1);
            chk("s6_seq", q, exp1[k]);
        end

        // Load of SEED must not raise wrap.
        cyc(0, 1, SEED, 1);
        chk("seed_load_wrap", wrap, 1'b0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 49) == 0,
                $urandom_range(0, 9) == 0,
                4'($urandom_range(0, 15)),
                $urandom_range(0, 3) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
